// File: rtl/md_sched_pkg.sv
// Shared types and constants for the position-update timestep sequencer.
package md_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FWAIT,
    ARM,
    RUN,
    CLEAR,
    SWAP,
    ERR
  } sched_state_e;

  localparam logic [1:0]  BANK0        = 2'b01;
  localparam logic [1:0]  BANK1        = 2'b10;
  localparam logic [32:0] INVALID_ADDR = {1'b1, 32'b0};

  function automatic logic [1:0] bank_flip(input logic [1:0] bank);
    return (bank == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/pos_update_sched_if.sv
// Host/updater-facing signal bundle of the timestep sequencer.
interface pos_update_sched_if #(
  parameter int NCELLS = 27
);
  logic              start;
  logic [15:0]       num_steps;
  logic              force_done;
  logic [NCELLS-1:0] upd_done;
  logic [NCELLS-1:0] ring_valid;
  logic              force_start;
  logic              ready;
  logic [1:0]        double_buffer;
  logic [32:0]       overwrite_addr;
  logic [15:0]       step_count;
  logic              step_done;
  logic              all_done;
  logic              busy;
  logic              err;

  modport master (
    output start, num_steps, force_done, upd_done, ring_valid,
    input  force_start, ready, double_buffer, overwrite_addr,
           step_count, step_done, all_done, busy, err
  );

  modport slave (
    input  start, num_steps, force_done, upd_done, ring_valid,
    output force_start, ready, double_buffer, overwrite_addr,
           step_count, step_done, all_done, busy, err
  );
endinterface

// File: rtl/quiesce_detect.sv
// Update-phase completion detector: idle-ring quiet counter and phase timeout counter.
module quiesce_detect
  import md_sched_pkg::*;
#(
  parameter int NCELLS       = 27,
  parameter int QUIET_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [NCELLS-1:0] upd_done,
  input  logic [NCELLS-1:0] ring_valid,
  output logic              quiet_hit,
  output logic              timeout_hit
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [QW-1:0] quiet_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [QW-1:0] quiet_nxt;
  logic [TW-1:0] tmo_nxt;
  logic          idle_now;

  assign idle_now = (&upd_done) && !(|ring_valid);

  always_comb begin
    quiet_nxt = '0;
    if (idle_now) quiet_nxt = quiet_cnt + QW'(1);
    tmo_nxt = tmo_cnt + TW'(1);
  end

  // Hits look at the post-increment value so the FSM exits on the Nth qualifying cycle.
  assign quiet_hit   = enable && (quiet_nxt == QW'(QUIET_CYCLES));
  assign timeout_hit = enable && (tmo_nxt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      quiet_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (enable) begin
      quiet_cnt <= quiet_nxt;
      tmo_cnt   <= tmo_nxt;
    end
  end

endmodule

// File: rtl/pos_update_sched.sv
// Timestep sequencer: force phase, update phase, stale-bank sweep, buffer swap.
module pos_update_sched
  import md_sched_pkg::*;
#(
  parameter int NCELLS       = 27,
  parameter int DBSIZE       = 256,
  parameter int QUIET_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input logic              clk,
  input logic              rst,
  pos_update_sched_if.slave bus
);

  localparam int IW = $clog2(DBSIZE) + 1;

  sched_state_e  state;
  logic [15:0]   steps_lat;
  logic [IW-1:0] sweep_idx;
  logic [31:0]   base;
  logic          quiet_hit;
  logic          timeout_hit;
  logic          in_run;
  logic          qd_clear;

  assign in_run   = (state == RUN);
  assign qd_clear = (state == ARM);
  assign base     = (bus.double_buffer == BANK0) ? 32'(DBSIZE) : '0;

  quiesce_detect #(
    .NCELLS      (NCELLS),
    .QUIET_CYCLES(QUIET_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) u_quiesce (
    .clk        (clk),
    .rst        (rst),
    .clear      (qd_clear),
    .enable     (in_run),
    .upd_done   (bus.upd_done),
    .ring_valid (bus.ring_valid),
    .quiet_hit  (quiet_hit),
    .timeout_hit(timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      steps_lat          <= '0;
      sweep_idx          <= '0;
      bus.ready          <= 1'b0;
      bus.double_buffer  <= BANK0;
      bus.overwrite_addr <= INVALID_ADDR;
      bus.force_start    <= 1'b0;
      bus.step_count     <= '0;
      bus.step_done      <= 1'b0;
      bus.all_done       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.err            <= 1'b0;
    end else begin
      bus.force_start <= 1'b0;
      bus.step_done   <= 1'b0;
      bus.all_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            steps_lat      <= bus.num_steps;
            bus.step_count <= '0;
            if (bus.num_steps == 16'd0) begin
              bus.all_done <= 1'b1;
            end else begin
              bus.force_start <= 1'b1;
              bus.busy        <= 1'b1;
              state           <= FWAIT;
            end
          end
        end
        FWAIT: begin
          if (bus.force_done) state <= ARM;
        end
        ARM: begin
          bus.ready <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (quiet_hit) begin
            bus.overwrite_addr <= {1'b0, base};
            sweep_idx          <= IW'(1);
            state              <= CLEAR;
          end else if (timeout_hit) begin
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
            bus.err   <= 1'b1;
            state     <= ERR;
          end
        end
        CLEAR: begin
          if (sweep_idx == IW'(DBSIZE)) begin
            // Swap-cycle outputs are registered on entry so they are visible during SWAP.
            bus.overwrite_addr <= INVALID_ADDR;
            bus.ready          <= 1'b0;
            bus.double_buffer  <= bank_flip(bus.double_buffer);
            bus.step_count     <= bus.step_count + 16'd1;
            bus.step_done      <= 1'b1;
            if ((bus.step_count + 16'd1) == steps_lat) bus.all_done <= 1'b1;
            state <= SWAP;
          end else begin
            bus.overwrite_addr <= {1'b0, base + 32'(sweep_idx)};
            sweep_idx          <= sweep_idx + IW'(1);
          end
        end
        SWAP: begin
          if (bus.step_count == steps_lat) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            bus.force_start <= 1'b1;
            state           <= FWAIT;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_update_sched.sv
// Directed self-checking bench for the timestep sequencer (DBSIZE=8, TIMEOUT=64).
module tb_pos_update_sched;
  import md_sched_pkg::*;

  localparam int NCELLS = 27;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pos_update_sched_if #(.NCELLS(NCELLS)) bus ();

  pos_update_sched #(
    .NCELLS      (NCELLS),
    .DBSIZE      (8),
    .QUIET_CYCLES(4),
    .TIMEOUT     (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.num_steps  = '0;
    bus.force_done = 1'b0;
    bus.upd_done   = '0;
    bus.ring_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.start     = 1'b1;
    bus.num_steps = 16'd5;
    bus.force_done = 1'b0;
    bus.upd_done   = '0;
    bus.ring_valid = '0;
    repeat (3) tick();
    n_checks++;
    if ({bus.ready, bus.double_buffer} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_bank: ready/db=%b expected 001", {bus.ready, bus.double_buffer});
    end
    n_checks++;
    if (bus.overwrite_addr !== 33'h1_0000_0000) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected 100000000", bus.overwrite_addr);
    end
    n_checks++;
    if ({bus.force_start, bus.step_done, bus.all_done, bus.busy, bus.err, bus.step_count} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_flags: fs/sd/ad/busy/err/sc=%b expected all zero",
               {bus.force_start, bus.step_done, bus.all_done, bus.busy, bus.err, bus.step_count});
    end
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_step();
    int n;
    do_reset();
    bus.num_steps = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.force_start, bus.busy, bus.ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL single_launch: fs/busy/ready=%b expected 110", {bus.force_start, bus.busy, bus.ready});
    end
    repeat (5) tick();
    bus.force_done = 1'b1;
    tick();
    bus.force_done = 1'b0;
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_arm_ready: got %b expected 0", bus.ready);
    end
    tick();
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_run_ready: got %b expected 1", bus.ready);
    end
    repeat (10) tick();
    bus.upd_done = '1;
    n = 0;
    while (bus.overwrite_addr[32] && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL single_quiet_len: cycles to CLEAR %0d expected 4", n);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (bus.overwrite_addr !== 33'(8 + k)) begin
        n_fail++;
        $display("FAIL single_sweep[%0d]: addr %h expected %h", k, bus.overwrite_addr, 33'(8 + k));
      end
      tick();
    end
    n_checks++;
    if ({bus.overwrite_addr[32], bus.double_buffer, bus.step_done, bus.all_done, bus.ready} !== 6'b1_10_110) begin
      n_fail++;
      $display("FAIL single_swap: idle/db/sd/ad/ready=%b expected 110110",
               {bus.overwrite_addr[32], bus.double_buffer, bus.step_done, bus.all_done, bus.ready});
    end
    n_checks++;
    if (bus.step_count !== 16'd1) begin
      n_fail++;
      $display("FAIL single_step_count: got %0d expected 1", bus.step_count);
    end
    tick();
    n_checks++;
    if ({bus.busy, bus.step_done, bus.all_done, bus.force_start} !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: busy/sd/ad/fs=%b expected 0000",
               {bus.busy, bus.step_done, bus.all_done, bus.force_start});
    end
    bus.upd_done = '0;
  endtask

  task automatic test_migration_restart();
    int n;
    do_reset();
    bus.num_steps  = 16'd1;
    bus.force_done = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.upd_done = '1;
    repeat (3) tick();
    bus.ring_valid[3] = 1'b1;
    tick();
    bus.ring_valid[3] = 1'b0;
    n = 0;
    while (bus.overwrite_addr[32] && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL migr_restart: cycles from ring idle to CLEAR %0d expected 4", n);
    end
    n_checks++;
    if (bus.overwrite_addr !== 33'h0_0000_0008) begin
      n_fail++;
      $display("FAIL migr_base: addr %h expected 8", bus.overwrite_addr);
    end
    n = 0;
    while (!bus.all_done && n < 30) begin
      tick();
      n++;
    end
    n_checks++;
    if (bus.all_done !== 1'b1) begin
      n_fail++;
      $display("FAIL migr_done: all_done %b expected 1 within 30 cycles", bus.all_done);
    end
    bus.force_done = 1'b0;
    bus.upd_done   = '0;
  endtask

  task automatic test_multi_step();
    int          fs_cnt, ad_cnt, nb, nd;
    logic        prev_idle;
    logic [32:0] bases [3];
    logic [1:0]  dbs   [3];
    logic [15:0] scs   [3];
    do_reset();
    bus.force_done = 1'b1;
    bus.upd_done   = '1;
    bus.num_steps  = 16'd3;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    fs_cnt = 0; ad_cnt = 0; nb = 0; nd = 0; prev_idle = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (bus.force_start) fs_cnt++;
      if (!bus.overwrite_addr[32] && prev_idle) begin
        if (nb < 3) bases[nb] = bus.overwrite_addr;
        nb++;
      end
      prev_idle = bus.overwrite_addr[32];
      if (bus.step_done) begin
        if (nd < 3) begin
          dbs[nd] = bus.double_buffer;
          scs[nd] = bus.step_count;
        end
        nd++;
      end
      if (bus.all_done) ad_cnt++;
      tick();
    end
    n_checks++;
    if (fs_cnt !== 3) begin
      n_fail++;
      $display("FAIL multi_force_start: %0d pulses expected 3", fs_cnt);
    end
    n_checks++;
    if (ad_cnt !== 1) begin
      n_fail++;
      $display("FAIL multi_all_done: %0d pulses expected 1", ad_cnt);
    end
    n_checks++;
    if (nb !== 3 || nd !== 3) begin
      n_fail++;
      $display("FAIL multi_counts: sweeps %0d steps %0d expected 3 and 3", nb, nd);
    end else begin
      n_checks++;
      if ({bases[0], bases[1], bases[2]} !== {33'd8, 33'd0, 33'd8}) begin
        n_fail++;
        $display("FAIL multi_bases: %0d,%0d,%0d expected 8,0,8", bases[0], bases[1], bases[2]);
      end
      n_checks++;
      if ({dbs[0], dbs[1], dbs[2]} !== 6'b10_01_10) begin
        n_fail++;
        $display("FAIL multi_db: %b %b %b expected 10 01 10", dbs[0], dbs[1], dbs[2]);
      end
      n_checks++;
      if ({scs[0], scs[1], scs[2]} !== {16'd1, 16'd2, 16'd3}) begin
        n_fail++;
        $display("FAIL multi_step_count: %0d,%0d,%0d expected 1,2,3", scs[0], scs[1], scs[2]);
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_busy_end: got %b expected 0", bus.busy);
    end
    bus.force_done = 1'b0;
    bus.upd_done   = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.num_steps  = 16'd1;
    bus.force_done = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    repeat (63) tick();
    n_checks++;
    if ({bus.err, bus.ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL tmo_before: err/ready=%b expected 01 after 63 RUN cycles", {bus.err, bus.ready});
    end
    tick();
    n_checks++;
    if ({bus.err, bus.ready, bus.busy, bus.overwrite_addr[32]} !== 4'b1001) begin
      n_fail++;
      $display("FAIL tmo_err: err/ready/busy/idle=%b expected 1001",
               {bus.err, bus.ready, bus.busy, bus.overwrite_addr[32]});
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++;
    if ({bus.err, bus.force_start, bus.busy, bus.ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL tmo_start_ignored: err/fs/busy/ready=%b expected 1000",
               {bus.err, bus.force_start, bus.busy, bus.ready});
    end
    do_reset();
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_rst_clear: err %b expected 0", bus.err);
    end
  endtask

  task automatic test_edge_cases();
    int n;
    do_reset();
    bus.num_steps = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if ({bus.all_done, bus.force_start, bus.busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL zero_steps: ad/fs/busy=%b expected 100", {bus.all_done, bus.force_start, bus.busy});
    end
    tick();
    n_checks++;
    if ({bus.all_done, bus.force_start, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL zero_steps_after: ad/fs/busy=%b expected 000", {bus.all_done, bus.force_start, bus.busy});
    end

    do_reset();
    bus.force_done = 1'b1;
    bus.upd_done   = '1;
    bus.num_steps  = 16'd2;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.overwrite_addr[32] && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (bus.overwrite_addr !== 33'd8) begin
      n_fail++;
      $display("FAIL clr_start_first: addr %h expected 8", bus.overwrite_addr);
    end
    bus.num_steps = 16'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      n_checks++;
      if (bus.overwrite_addr !== 33'(8 + k)) begin
        n_fail++;
        $display("FAIL clr_start_sweep[%0d]: addr %h expected %h", k, bus.overwrite_addr, 33'(8 + k));
      end
      tick();
    end
    n_checks++;
    if ({bus.step_done, bus.all_done, bus.step_count} !== {2'b10, 16'd1}) begin
      n_fail++;
      $display("FAIL clr_start_swap: sd/ad=%b sc=%0d expected 10 and 1",
               {bus.step_done, bus.all_done}, bus.step_count);
    end
    n = 0;
    while (!bus.all_done && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if ({bus.all_done, bus.step_count} !== {1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL clr_start_done: ad=%b sc=%0d expected 1 and 2", bus.all_done, bus.step_count);
    end
    bus.force_done = 1'b0;
    bus.upd_done   = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    test_reset();
    test_single_step();
    test_migration_restart();
    test_multi_step();
    test_timeout();
    test_edge_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
